// File: rtl/ram_loader.sv
// ram_loader: streams RAM_DEPTH bytes into the program RAM, reads them back and
// compares additive checksums while holding the CPU in reset.
module ram_loader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RAM_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [DATA_WIDTH-1:0] byte_data,
   output logic                  byte_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] checksum
);
   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, RD_ADDR, RD_WAIT, CHECK, DONE, ERROR} state_t;
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
   state_t                state_q;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] wsum_q, rsum_q;
   logic                  byte_ready_q, ram_we_q, cpu_hold_q, busy_q, done_q, error_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, checksum_q;
   assign cnt_d = cnt_q + 1'b1;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wsum_q       <= '0;
         rsum_q       <= '0;
         byte_ready_q <= 1'b0;
         ram_we_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         checksum_q   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE, ERROR: if (start) begin
               state_q      <= ACCEPT;
               cnt_q        <= '0;
               wsum_q       <= '0;
               rsum_q       <= '0;
               done_q       <= 1'b0;
               error_q      <= 1'b0;
               cpu_hold_q   <= 1'b1;
               busy_q       <= 1'b1;
               byte_ready_q <= 1'b1;
            end
            ACCEPT: if (byte_valid && byte_ready_q) begin
               wdata_q      <= byte_data;
               addr_q       <= cnt_q[ADDR_WIDTH-1:0];
               byte_ready_q <= 1'b0;
               ram_we_q     <= 1'b1;
               state_q      <= WRITE;
            end
            WRITE: begin
               ram_we_q <= 1'b0;
               wsum_q   <= wsum_q + wdata_q;
               if (cnt_d == DEPTH) begin
                  cnt_q   <= '0;
                  addr_q  <= '0;
                  state_q <= RD_ADDR;
               end else begin
                  cnt_q        <= cnt_d;
                  byte_ready_q <= 1'b1;
                  state_q      <= ACCEPT;
               end
            end
            // address already presented on entry; RAM registers it at the end of this cycle
            RD_ADDR: state_q <= RD_WAIT;
            RD_WAIT: begin
               rsum_q <= rsum_q + ram_rdata;
               cnt_q  <= cnt_d;
               if (cnt_d == DEPTH) state_q <= CHECK;
               else begin
                  addr_q  <= cnt_d[ADDR_WIDTH-1:0];
                  state_q <= RD_ADDR;
               end
            end
            CHECK: begin
               checksum_q <= wsum_q;
               done_q     <= (wsum_q == rsum_q);
               error_q    <= (wsum_q != rsum_q);
               cpu_hold_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= (wsum_q == rsum_q) ? DONE : ERROR;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign byte_ready  = byte_ready_q;
   assign ram_we      = ram_we_q;
   assign ram_address = addr_q;
   assign ram_wdata   = wdata_q;
   assign cpu_hold    = cpu_hold_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign checksum    = checksum_q;
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Initiator/writer side of the single-port program RAM's write port.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Writes RAM_DEPTH bytes sequentially from address 0, then reads every location back and checks an 8-bit additive checksum.
- Holds the CPU in reset for the whole operation, so a program can be loaded at runtime instead of through the synthesis-time initial image.

Parameters:
- ADDR_WIDTH, 4, RAM address width (matches arch_defs_pkg).
- DATA_WIDTH, 8, RAM word width (matches arch_defs_pkg).
- RAM_DEPTH, 16, number of words to load; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  DATA_WIDTH  incoming program byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- ram_we  output  1  RAM write enable.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  to RAM data_in.
- ram_rdata  input  DATA_WIDTH  from RAM data_out; registered, valid 1 cycle after the address is presented.
- cpu_hold  output  1  holds the CPU in reset while high.
- busy  output  1  high in any state other than IDLE, DONE or ERROR.
- done  output  1  load verified OK; sticky.
- error  output  1  checksum mismatch; sticky.
- checksum  output  DATA_WIDTH  sum of written bytes, modulo 2**DATA_WIDTH.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset_n=0) puts the block in IDLE and drives all outputs to 0: byte_ready, ram_we, ram_address, ram_wdata, cpu_hold, busy, done, error, checksum.
- The address counter is ADDR_WIDTH+1 bits wide, so a count of RAM_DEPTH is distinguishable from 0.
- States: IDLE, ACCEPT, WRITE, RD_ADDR, RD_WAIT, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start=1 → ACCEPT.
  - Clears the counter, write sum, read sum, done and error.
  - Sets cpu_hold=1 and busy=1.
- ACCEPT:
  - byte_ready=1.
  - On byte_valid&&byte_ready, capture byte_data into ram_wdata, set ram_address to the counter, deassert byte_ready and go to WRITE.
  - byte_ready is never high in any other state.
- WRITE:
  - ram_we=1 for exactly one cycle.
  - Write sum += ram_wdata; counter++.
  - If the new count == RAM_DEPTH: clear the counter and go to RD_ADDR; otherwise return to ACCEPT.
  - Each byte takes at least 2 cycles.
- RD_ADDR: ram_we=0; ram_address=counter; go to RD_WAIT.
- RD_WAIT:
  - Wait one cycle for the registered RAM read.
  - Next state samples ram_rdata: read sum += ram_rdata; counter++.
  - If count == RAM_DEPTH → CHECK, else → RD_ADDR.
  - Each read takes 2 cycles per address.
- CHECK:
  - checksum ← write sum.
  - Equal sums → DONE (done=1); unequal → ERROR (error=1).
  - In both cases cpu_hold=0 and busy=0, taking effect on the same edge.
- Total latency with byte_valid held high: 2*RAM_DEPTH (load) + 2*RAM_DEPTH (verify) + 1 cycle from the first ACCEPT to done.
- start while busy is ignored; there is no restart mid-operation.
- byte_valid outside ACCEPT is ignored and the byte is not consumed, because byte_ready=0.
- Sums wrap modulo 2**DATA_WIDTH.
- ram_address wraps naturally; it never exceeds RAM_DEPTH-1 in practice.
- Reset mid-load: immediate return to IDLE, cpu_hold drops and ram_we drops. RAM contents are left partially written and the block does not restore them.
- start in DONE or ERROR clears done/error on the next edge and begins a new load.

Test Plan:
- Reset, then start with bytes 1F 4E E0 86 E0 90 00×8 0A 0F presented back-to-back → 16 single-cycle ram_we pulses at addresses 0..15 with matching data, then 16 reads, done=1, error=0, checksum=0x5C, cpu_hold 1→0.
- Same stream with byte_valid toggling every 3rd cycle → no lost or duplicated bytes, byte_ready low in WRITE, final RAM dump identical to the first scenario, done=1.
- RAM model corrupts address 7 on readback (0x00→0x01) → error=1, done=0, checksum=0x5C, cpu_hold=0.
- Assert reset_n=0 after the 5th byte → all outputs 0 asynchronously (ram_we=0 immediately); the next start reloads from address 0 and ends with done=1.
- Pulse start during LOAD and during verify → ignored; sequence and timing unchanged; a start pulse after done clears done the next cycle and busy=1.
- All bytes 0xFF → checksum=0xF0 (wrap), done=1.
